// File: rtl/id_ex_stage.sv
// ID/EX stage: decodes an RV32I instruction, reads the regfile combinationally
// and holds the resulting alu operands and control fields in a one-entry
// valid/ready output register.
module id_ex_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  instr_valid_i,
  output logic                  instr_ready_o,
  input  logic [31:0]           instr_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic                  flush_i,
  output logic [REG_ADDR_W-1:0] rs1_addr_o,
  output logic [REG_ADDR_W-1:0] rs2_addr_o,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data1_o,
  output logic [DATA_WIDTH-1:0] data2_o,
  output logic [6:0]            opcode_o,
  output logic [2:0]            func3_o,
  output logic [6:0]            func7_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic                  rd_we_o,
  output logic                  is_load_o,
  output logic                  is_store_o,
  output logic [2:0]            mem_func3_o,
  output logic [DATA_WIDTH-1:0] store_data_o,
  output logic                  illegal_o,
  output logic [DATA_WIDTH-1:0] pc_o
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data1;
    logic [DATA_WIDTH-1:0] data2;
    logic [6:0]            opcode;
    logic [2:0]            func3;
    logic [6:0]            func7;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  rd_we;
    logic                  is_load;
    logic                  is_store;
    logic [2:0]            mem_func3;
    logic [DATA_WIDTH-1:0] store_data;
    logic                  illegal;
    logic [DATA_WIDTH-1:0] pc;
  } entry_t;

  entry_t                dec;
  entry_t                ent_q;
  logic                  valid_q;
  logic                  capture;
  logic [DATA_WIDTH-1:0] imm_i;
  logic [DATA_WIDTH-1:0] imm_s;
  logic [DATA_WIDTH-1:0] imm_u;

  // Handshake: a slot is free when empty, draining, or being flushed.
  assign instr_ready_o = !valid_q || ready_i || flush_i;
  assign capture       = instr_valid_i && instr_ready_o && !flush_i;

  assign rs1_addr_o = REG_ADDR_W'(instr_i[19:15]);
  assign rs2_addr_o = REG_ADDR_W'(instr_i[24:20]);

  assign imm_i = {{(DATA_WIDTH-12){instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{(DATA_WIDTH-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_u = DATA_WIDTH'({instr_i[31:12], 12'b0});

  // Decode the offered instruction into the next entry; non-R forms reuse the alu's add path.
  always_comb begin
    dec         = '0;
    dec.opcode  = OP_IMM;
    dec.rd_addr = REG_ADDR_W'(instr_i[11:7]);
    dec.pc      = pc_i;
    case (instr_i[6:0])
      OP_R: begin
        dec.data1  = rs1_data_i;
        dec.data2  = rs2_data_i;
        dec.opcode = OP_R;
        dec.func3  = instr_i[14:12];
        dec.func7  = instr_i[31:25];
        dec.rd_we  = 1'b1;
      end
      OP_IMM: begin
        dec.data1 = rs1_data_i;
        dec.data2 = imm_i;
        dec.func3 = instr_i[14:12];
        if (instr_i[14:12] == 3'b001 || instr_i[14:12] == 3'b101) begin
          dec.func7 = instr_i[31:25];
        end
        dec.rd_we = 1'b1;
      end
      OP_LOAD: begin
        dec.data1     = rs1_data_i;
        dec.data2     = imm_i;
        dec.is_load   = 1'b1;
        dec.mem_func3 = instr_i[14:12];
        dec.rd_we     = 1'b1;
      end
      OP_STORE: begin
        dec.data1      = rs1_data_i;
        dec.data2      = imm_s;
        dec.is_store   = 1'b1;
        dec.store_data = rs2_data_i;
        dec.mem_func3  = instr_i[14:12];
      end
      OP_LUI: begin
        dec.data2 = imm_u;
        dec.rd_we = 1'b1;
      end
      OP_AUIPC: begin
        dec.data1 = pc_i;
        dec.data2 = imm_u;
        dec.rd_we = 1'b1;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
    if (dec.rd_addr == '0) begin
      dec.rd_we = 1'b0;
    end
  end

  // Output register: flush empties, capture loads, a drained entry with nothing behind it empties.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      ent_q   <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q <= 1'b1;
      ent_q   <= dec;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o      = valid_q;
  assign data1_o      = ent_q.data1;
  assign data2_o      = ent_q.data2;
  assign opcode_o     = ent_q.opcode;
  assign func3_o      = ent_q.func3;
  assign func7_o      = ent_q.func7;
  assign rd_addr_o    = ent_q.rd_addr;
  assign rd_we_o      = ent_q.rd_we;
  assign is_load_o    = ent_q.is_load;
  assign is_store_o   = ent_q.is_store;
  assign mem_func3_o  = ent_q.mem_func3;
  assign store_data_o = ent_q.store_data;
  assign illegal_o    = ent_q.illegal;
  assign pc_o         = ent_q.pc;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed cases followed by a random
// run scored against a queue-based reference of the output slot.
module tb_id_ex_stage;

  typedef struct packed {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic        we;
    logic        ld;
    logic        st;
    logic [2:0]  mf3;
    logic [31:0] sd;
    logic        ill;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ivalid;
  logic        iready;
  logic [31:0] instr;
  logic [31:0] pc_in;
  logic        flush;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        valid;
  logic        ready;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [4:0]  rd_addr;
  logic        rd_we;
  logic        is_load;
  logic        is_store;
  logic [2:0]  mem_func3;
  logic [31:0] store_data;
  logic        illegal;
  logic [31:0] pc_out;

  logic [31:0] rf [32];
  int n_cmp  = 0;
  int n_fail = 0;

  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk_i(clk), .rst_i(rst),
    .instr_valid_i(ivalid), .instr_ready_o(iready),
    .instr_i(instr), .pc_i(pc_in), .flush_i(flush),
    .rs1_addr_o(rs1_addr), .rs2_addr_o(rs2_addr),
    .rs1_data_i(rs1_data), .rs2_data_i(rs2_data),
    .valid_o(valid), .ready_i(ready),
    .data1_o(data1), .data2_o(data2), .opcode_o(opcode),
    .func3_o(func3), .func7_o(func7),
    .rd_addr_o(rd_addr), .rd_we_o(rd_we),
    .is_load_o(is_load), .is_store_o(is_store),
    .mem_func3_o(mem_func3), .store_data_o(store_data),
    .illegal_o(illegal), .pc_o(pc_out)
  );

  // Reference decode straight from the instruction-format rules.
  function automatic ent_t ref_decode(input logic [31:0] ins, input logic [31:0] a,
                                      input logic [31:0] b, input logic [31:0] pc);
    ent_t e;
    int   imm12;
    e    = '0;
    e.pc = pc;
    e.rd = ins[11:7];
    e.op = 7'h13;
    imm12 = int'(ins[31:20]);
    if (imm12 >= 2048) imm12 = imm12 - 4096;
    case (ins[6:0])
      7'h33: begin e.d1 = a; e.d2 = b; e.op = 7'h33; e.f3 = ins[14:12]; e.f7 = ins[31:25]; e.we = 1'b1; end
      7'h13: begin
        e.d1 = a; e.d2 = 32'(imm12); e.f3 = ins[14:12]; e.we = 1'b1;
        e.f7 = (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) ? ins[31:25] : 7'd0;
      end
      7'h03: begin e.d1 = a; e.d2 = 32'(imm12); e.ld = 1'b1; e.mf3 = ins[14:12]; e.we = 1'b1; end
      7'h23: begin
        imm12 = int'({ins[31:25], ins[11:7]});
        if (imm12 >= 2048) imm12 = imm12 - 4096;
        e.d1 = a; e.d2 = 32'(imm12); e.st = 1'b1; e.sd = b; e.mf3 = ins[14:12];
      end
      7'h37: begin e.d2 = ins & 32'hFFFF_F000; e.we = 1'b1; end
      7'h17: begin e.d1 = pc; e.d2 = ins & 32'hFFFF_F000; e.we = 1'b1; end
      default: e.ill = 1'b1;
    endcase
    if (e.rd == 5'd0) e.we = 1'b0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ent(input string tag, input ent_t e);
    chk({tag, ".data1"}, data1, e.d1);
    chk({tag, ".data2"}, data2, e.d2);
    chk({tag, ".opcode"}, 32'(opcode), 32'(e.op));
    chk({tag, ".func3"}, 32'(func3), 32'(e.f3));
    chk({tag, ".func7"}, 32'(func7), 32'(e.f7));
    chk({tag, ".rd"}, 32'(rd_addr), 32'(e.rd));
    chk({tag, ".rd_we"}, 32'(rd_we), 32'(e.we));
    chk({tag, ".is_load"}, 32'(is_load), 32'(e.ld));
    chk({tag, ".is_store"}, 32'(is_store), 32'(e.st));
    chk({tag, ".mem_func3"}, 32'(mem_func3), 32'(e.mf3));
    chk({tag, ".store_data"}, store_data, e.sd);
    chk({tag, ".illegal"}, 32'(illegal), 32'(e.ill));
    chk({tag, ".pc"}, pc_out, e.pc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction for a single cycle and check the captured entry.
  task automatic send(input string tag, input logic [31:0] ins, input logic [31:0] pc);
    ent_t e;
    instr  = ins;
    pc_in  = pc;
    ivalid = 1'b1;
    #1;
    e = ref_decode(ins, rf[ins[19:15]], rf[ins[24:20]], pc);
    chk({tag, ".rs1_addr"}, 32'(rs1_addr), 32'(ins[19:15]));
    chk({tag, ".rs2_addr"}, 32'(rs2_addr), 32'(ins[24:20]));
    chk({tag, ".instr_ready"}, 32'(iready), 32'd1);
    tick();
    ivalid = 1'b0;
    chk({tag, ".valid"}, 32'(valid), 32'd1);
    chk_ent(tag, e);
  endtask

  initial begin
    ent_t q[$];
    ent_t held;
    logic cap;
    logic taken;

    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    rst = 1'b1; ivalid = 1'b0; instr = 32'd0; pc_in = 32'd0; flush = 1'b0; ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.valid", 32'(valid), 32'd0);
    chk("reset.instr_ready", 32'(iready), 32'd1);
    chk_ent("reset", '0);
    rst = 1'b0;
    tick();

    // Basic decode cases
    rf[1] = 32'd6; rf[2] = 32'd5;
    send("add", 32'h002081B3, 32'h0000_0040);
    chk("add.const_data1", data1, 32'd6);
    chk("add.const_opcode", 32'(opcode), 32'h33);
    rf[0] = 32'd0;
    send("addi", 32'hFFF00293, 32'h0000_0044);
    chk("addi.const_data2", data2, 32'hFFFF_FFFF);
    send("srai", 32'h4030D093, 32'h0000_0048);
    chk("srai.const_func7", 32'(func7), 32'h20);
    chk("srai.const_data2", data2, 32'h0000_0403);
    send("lui", 32'h123450B7, 32'h0000_004C);
    chk("lui.const_data2", data2, 32'h1234_5000);
    send("auipc", 32'h00001117, 32'h0000_0100);
    chk("auipc.const_data1", data1, 32'h0000_0100);
    chk("auipc.const_data2", data2, 32'h0000_1000);
    rf[1] = 32'h200; rf[2] = 32'hCAFE;
    send("sw", 32'h0020A423, 32'h0000_0104);
    chk("sw.const_store_data", store_data, 32'h0000_CAFE);
    chk("sw.const_data2", data2, 32'd8);
    send("lw", 32'hFFC12183, 32'h0000_0108);
    send("jal", 32'h008000EF, 32'h0000_010C);
    chk("jal.const_illegal", 32'(illegal), 32'd1);
    chk("jal.const_rd_we", 32'(rd_we), 32'd0);
    send("addi_x0", 32'h00108013, 32'h0000_0110);
    chk("addi_x0.const_rd_we", 32'(rd_we), 32'd0);
    tick();
    chk("drain.valid", 32'(valid), 32'd0);

    // Backpressure: hold three cycles, then back-to-back transfer
    rf[3] = 32'h11; rf[4] = 32'h22;
    ready = 1'b0;
    held = ref_decode(32'h004181B3, rf[3], rf[4], 32'h200);
    send("bp_a", 32'h004181B3, 32'h200);
    instr = 32'h00520313; pc_in = 32'h204; ivalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp.instr_ready", 32'(iready), 32'd0);
      tick();
      chk("bp.valid", 32'(valid), 32'd1);
      chk_ent("bp_hold", held);
    end
    ready = 1'b1;
    #1;
    chk("bp.release_ready", 32'(iready), 32'd1);
    held = ref_decode(32'h00520313, rf[4], rf[5], 32'h204);
    tick();
    ivalid = 1'b0;
    chk("bp.b2b_valid", 32'(valid), 32'd1);
    chk_ent("bp_b", held);
    tick();
    chk("bp.empty", 32'(valid), 32'd0);

    // Flush with a held entry and an offered instruction
    ready = 1'b0;
    send("fl_a", 32'h00108093, 32'h300);
    instr = 32'h00210113; pc_in = 32'h304; ivalid = 1'b1; flush = 1'b1;
    #1;
    chk("flush.instr_ready", 32'(iready), 32'd1);
    tick();
    flush = 1'b0; ivalid = 1'b0;
    chk("flush.valid", 32'(valid), 32'd0);
    ready = 1'b1;
    tick();
    chk("flush.never_appears", 32'(valid), 32'd0);

    // Asynchronous reset in the middle of a stall
    ready = 1'b0;
    send("rst_a", 32'h00108093, 32'h400);
    tick();
    chk("rst.stall_valid", 32'(valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst.async_valid", 32'(valid), 32'd0);
    chk("rst.async_data1", data1, 32'd0);
    chk("rst.async_pc", pc_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ready = 1'b1;
    tick();

    // Random run against a queue model of the output slot
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [6:0] opc;
      case ($urandom_range(0, 6))
        0: opc = 7'h33; 1: opc = 7'h13; 2: opc = 7'h03; 3: opc = 7'h23;
        4: opc = 7'h37; 5: opc = 7'h17; default: opc = 7'($urandom);
      endcase
      rf[$urandom_range(0, 31)] = $urandom;
      instr  = {25'($urandom), opc};
      pc_in  = $urandom & 32'hFFFF_FFFC;
      ivalid = ($urandom_range(0, 3) != 0);
      ready  = ($urandom_range(0, 2) != 0);
      flush  = ($urandom_range(0, 11) == 0);
      #1;
      chk("rnd.instr_ready", 32'(iready), 32'((q.size() == 0) || ready || flush));
      taken = (q.size() != 0) && ready;
      cap   = ivalid && ((q.size() == 0) || ready) && !flush;
      held  = ref_decode(instr, rf[instr[19:15]], rf[instr[24:20]], pc_in);
      if (flush) q.delete();
      else begin
        if (taken) void'(q.pop_front());
        if (cap) q.push_back(held);
      end
      tick();
      chk("rnd.valid", 32'(valid), 32'(q.size() != 0));
      if (q.size() != 0) chk_ent("rnd", q[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode stage with an ID/EX pipeline register, directly upstream of the alu.
- Takes a fetched RV32I instruction plus its PC, reads the register file combinationally, and builds the operands and control fields the alu consumes (data1, data2, opcode, func3, func7).
- Also forwards destination and memory-side information to later stages.
- Uses a valid/ready handshake on both sides, with a one-entry registered output.

Parameters:
DATA_WIDTH, 32, operand/PC width
REG_ADDR_W, 5, register index width

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous active-high reset
instr_valid_i  input  1  fetch offers an instruction
instr_ready_o  output  1  stage accepts an instruction this cycle
instr_i  input  32  instruction word
pc_i  input  DATA_WIDTH  PC of instr_i
flush_i  input  1  kill held entry and the incoming instruction
rs1_addr_o  output  REG_ADDR_W  regfile read address 1 = instr_i[19:15], combinational
rs2_addr_o  output  REG_ADDR_W  regfile read address 2 = instr_i[24:20], combinational
rs1_data_i  input  DATA_WIDTH  regfile read data 1, same cycle
rs2_data_i  input  DATA_WIDTH  regfile read data 2, same cycle
valid_o  output  1  registered entry valid
ready_i  input  1  downstream accepts entry
data1_o  output  DATA_WIDTH  alu operand 1
data2_o  output  DATA_WIDTH  alu operand 2
opcode_o  output  7  alu opcode (0110011 or 0010011)
func3_o  output  3  alu func3
func7_o  output  7  alu func7
rd_addr_o  output  REG_ADDR_W  destination register
rd_we_o  output  1  writeback enable
is_load_o  output  1  load instruction
is_store_o  output  1  store instruction
mem_func3_o  output  3  load/store width field
store_data_o  output  DATA_WIDTH  rs2 value for stores
illegal_o  output  1  unsupported opcode
pc_o  output  DATA_WIDTH  PC of held entry

Behaviour:
- Reset: valid_o=0; every registered output is 0.
- Handshake:
  - instr_ready_o = !valid_o || ready_i || flush_i.
  - Capture happens when instr_valid_i && instr_ready_o && !flush_i.
  - Latency is 1 cycle from capture to valid_o.
- Hold: while valid_o && !ready_i && !flush_i, all outputs are stable.
- valid_o next state:
  - 0 if flush_i.
  - 1 if captured.
  - 0 if (valid_o && ready_i) and nothing captured.
  - Otherwise unchanged.
- Flush: valid_o drops the next cycle, and the input offered during flush is consumed and discarded. Data registers may keep stale values.
- Decode by instr_i[6:0]:
  - R (0110011): data1=rs1, data2=rs2, opcode=0110011, func3=instr[14:12], func7=instr[31:25], rd_we=1.
  - OP-IMM (0010011): data1=rs1, data2=sext(instr[31:20]), opcode=0010011, func3=instr[14:12].
    - func7=instr[31:25] when func3 is 001 or 101 (shifts); otherwise func7=0.
    - rd_we=1.
  - LOAD (0000011): data1=rs1, data2=sext(instr[31:20]), opcode=0010011, func3=000, func7=0, is_load=1, mem_func3=instr[14:12], rd_we=1.
  - STORE (0100011): data1=rs1, data2=sext({instr[31:25],instr[11:7]}), opcode=0010011, func3=000, func7=0, is_store=1, store_data=rs2, mem_func3=instr[14:12], rd_we=0.
  - LUI (0110111): data1=0, data2={instr[31:12],12'b0}, opcode=0010011, func3=000, func7=0, rd_we=1.
  - AUIPC (0010111): data1=pc_i, data2={instr[31:12],12'b0}, opcode=0010011, func3=000, func7=0, rd_we=1.
  - Any other opcode: illegal_o=1, rd_we=0, is_load=0, is_store=0; data1, data2, func3, func7 all 0; opcode=0010011. The entry is still passed downstream with valid_o=1.
- Field defaults: rd_addr=instr[11:7]. rd_we is forced to 0 when rd_addr==0. is_load, is_store and illegal are 0 unless set above.
- No hazard detection or forwarding: operands are the regfile values sampled on the capture edge.

Test Plan:
1. ADD x3,x1,x2 (0x002081B3), rs1_data=6, rs2_data=5, ready_i=1 -> next cycle: valid_o=1, data1=6, data2=5, opcode=0110011, func3=000, func7=0, rd=3, rd_we=1; rs1_addr=1 and rs2_addr=2 during the offer cycle.
2. ADDI x5,x0,-1 (0xFFF00293), rs1_data=0 -> data2=0xFFFFFFFF, func7=0, rd=5. SRAI x1,x1,3 (0x4030D093) -> func3=101, func7=0100000, data2=0x00000403.
3. LUI x1,0x12345 (0x123450B7) -> data1=0, data2=0x12345000. AUIPC x2,1 (0x00001117) at pc_i=0x100 -> data1=0x100, data2=0x1000. Both: opcode=0010011, func3=000.
4. SW x2,8(x1) (0x0020A423), rs1_data=0x200, rs2_data=0xCAFE -> data1=0x200, data2=8, is_store=1, store_data=0xCAFE, mem_func3=010, rd_we=0.
5. Backpressure: hold ready_i=0 for 3 cycles with a valid entry -> instr_ready_o=0 and outputs stable. Raise ready_i with a new instruction offered -> back-to-back transfer, no bubble.
6. Flush and reset:
   - flush_i=1 with a held entry and an offered instruction -> valid_o=0 next cycle; the offered instruction never appears.
   - JAL opcode 1101111 -> illegal_o=1, rd_we=0.
   - rst_i asserted mid-stall -> valid_o=0 immediately, without waiting for a clock edge.
